// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - opcode, funct and ALU-op encodings shared by the decode stage
package decode_stage_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  // alt selects SUB/SRA; the caller decides when funct7[5] is meaningful
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// rtl/decode_stage_imm_gen.sv - sign-extended I/S/B/U/J immediate extraction
module imm_gen
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (inst[6:0])
      OPC_OP_IMM, OPC_JALR, OPC_LOAD: imm32 = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:  imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm32 = {inst[31:12], 12'b0};
      OPC_JAL:    imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:    imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I/RV32E decode with write-back bypass, load-use stall and ID/EX register
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  localparam int RAW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [RAW-1:0]  rs1_addr,
  output logic [RAW-1:0]  rs2_addr,
  input  logic [XLEN-1:0] rs1_rdata,
  input  logic [XLEN-1:0] rs2_rdata,
  input  logic            wb_we,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [RAW-1:0]  out_rd,
  output logic            out_rd_we,
  output logic [3:0]      out_alu_op,
  output logic            out_is_load,
  output logic            out_is_store,
  output logic            out_is_branch,
  output logic            out_is_jal,
  output logic            out_is_jalr,
  output logic            out_illegal
);

  localparam logic RV32E = (REG_NUM == 16);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RAW-1:0]  rd;
    logic            rd_we;
    logic [3:0]      alu_op;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            illegal;
  } idex_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RAW-1:0]  rd_a;
  logic            known, funct_ok, has_rd, uses_rs1, uses_rs2, bad_reg, illegal;
  logic            is_load, is_store, is_branch, is_jal, is_jalr;
  alu_op_e         alu_op;
  logic [XLEN-1:0] imm, rs1_fwd, rs2_fwd;
  logic            hazard, accept;
  logic            valid_q, valid_d;
  idex_t           idex_q, idex_d, dec;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign funct7   = in_inst[31:25];
  assign rd_a     = in_inst[11:7];
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (in_inst),
    .imm  (imm)
  );

  always_comb begin
    known     = 1'b1;
    funct_ok  = 1'b1;
    has_rd    = 1'b1;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    alu_op    = ALU_ADD;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        uses_rs1 = 1'b1;
        alu_op   = alu_from_funct3(funct3, (funct3 == F3_SR) && funct7[5]);
        if (funct3 == F3_SLL)     funct_ok = (funct7 == F7_BASE);
        else if (funct3 == F3_SR) funct_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
      end
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        alu_op   = alu_from_funct3(funct3, funct7[5]);
        funct_ok = (funct7 == F7_BASE) ||
                   ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
      end
      OPC_LUI:   alu_op = ALU_PASSB;
      OPC_AUIPC: ;
      OPC_JAL:   is_jal = 1'b1;
      OPC_JALR: begin
        uses_rs1 = 1'b1;
        is_jalr  = 1'b1;
        funct_ok = (funct3 == F3_JALR);
      end
      OPC_BRANCH: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        is_branch = 1'b1;
        has_rd    = 1'b0;
        alu_op    = ALU_SUB;
        funct_ok  = (funct3[2:1] != 2'b01);
      end
      OPC_LOAD: begin
        uses_rs1 = 1'b1;
        is_load  = 1'b1;
        funct_ok = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        is_store = 1'b1;
        has_rd   = 1'b0;
        funct_ok = !funct3[2] && (funct3[1:0] != 2'b11);
      end
      default: known = 1'b0;
    endcase
  end

  // RV32E only has x0..x15, so any used index with bit 4 set is out of range
  assign bad_reg = RV32E && ((has_rd && rd_a[4]) || (uses_rs1 && rs1_addr[4]) ||
                             (uses_rs2 && rs2_addr[4]));
  assign illegal = !known || !funct_ok || bad_reg;

  assign rs1_fwd = (rs1_addr == '0) ? '0 :
                   (wb_we && (wb_rd == rs1_addr)) ? wb_data : rs1_rdata;
  assign rs2_fwd = (rs2_addr == '0) ? '0 :
                   (wb_we && (wb_rd == rs2_addr)) ? wb_data : rs2_rdata;

  always_comb begin
    dec.pc        = in_pc;
    dec.inst      = in_inst;
    dec.rs1_data  = rs1_fwd;
    dec.rs2_data  = rs2_fwd;
    dec.imm       = imm;
    dec.rd        = rd_a;
    dec.rd_we     = !illegal && has_rd && (rd_a != '0);
    dec.alu_op    = illegal ? ALU_ADD : alu_op;
    dec.is_load   = is_load;
    dec.is_store  = is_store;
    dec.is_branch = is_branch;
    dec.is_jal    = is_jal;
    dec.is_jalr   = is_jalr;
    dec.illegal   = illegal;
  end

  assign hazard = valid_q && idex_q.is_load && idex_q.rd_we && in_valid &&
                  ((uses_rs1 && (rs1_addr == idex_q.rd)) ||
                   (uses_rs2 && (rs2_addr == idex_q.rd)));
  assign in_ready = !hazard && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    idex_d  = idex_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      idex_d  = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idex_q  <= idex_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = idex_q.pc;
  assign out_inst      = idex_q.inst;
  assign out_rs1_data  = idex_q.rs1_data;
  assign out_rs2_data  = idex_q.rs2_data;
  assign out_imm       = idex_q.imm;
  assign out_rd        = idex_q.rd;
  assign out_rd_we     = idex_q.rd_we;
  assign out_alu_op    = idex_q.alu_op;
  assign out_is_load   = idex_q.is_load;
  assign out_is_store  = idex_q.is_store;
  assign out_is_branch = idex_q.is_branch;
  assign out_is_jal    = idex_q.is_jal;
  assign out_is_jalr   = idex_q.is_jalr;
  assign out_illegal   = idex_q.illegal;

endmodule
